t_pulse_debounce: RTL and testbench
===================================

Name: t_pulse_debounce

Overview:
- Upstream stage for the team's toggle flip-flop.
- Takes a raw, asynchronous, bouncing push-button or switch input and synchronises and debounces it.
- Emits exactly one single-cycle toggle pulse per debounced press, suitable for driving the flip-flop's t input.
- Also exports the debounced level and a busy flag for status LEDs and test.

Parameters:
- SYNC_STAGES, 2, number of flops in the input synchroniser chain; legal values 2..4.
- DEBOUNCE_CYCLES, 50000, number of consecutive clk cycles of stable input required to accept a level change; must be ≥ 1.
- CNT_W, 16, width of the debounce counter; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 500000, auto-repeat period in clk cycles; used only with AUTO_REPEAT_EN.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- rstn, input, 1, synchronous active-low reset.
- btn_in, input, 1, raw asynchronous button level (1 = pressed).
- tog_en, input, 1, toggle enable; 0 suppresses t_out without disturbing level tracking.
- t_out, output, 1, registered one-cycle toggle pulse; connects to the downstream t input.
- btn_level, output, 1, registered debounced button level.
- busy, output, 1, high while a candidate level change is being qualified.

Behaviour:
- Reset: when rstn=0 at a rising edge, all of the following clear:
  - synchroniser flops, state, and counter → 0 / IDLE_LO;
  - t_out=0, btn_level=0, busy=0.
- Reset mid-qualification discards the candidate change; no pulse is generated.
- Synchroniser: btn_in passes through SYNC_STAGES flops to produce s_in. Only s_in feeds the FSM.
- FSM states and transitions:
  - IDLE_LO: if s_in=1 → WAIT_HI with cnt←0.
  - WAIT_HI:
    - If s_in=0 → IDLE_LO with cnt←0 (bounce rejected).
    - Else if cnt==DEBOUNCE_CYCLES-1 → IDLE_HI, btn_level←1, t_out←tog_en.
    - Else cnt←cnt+1.
  - IDLE_HI: if s_in=0 → WAIT_LO with cnt←0.
  - WAIT_LO:
    - If s_in=1 → IDLE_HI with cnt←0.
    - Else if cnt==DEBOUNCE_CYCLES-1 → IDLE_LO, btn_level←0. No pulse on release.
    - Else cnt←cnt+1.
- t_out:
  - High for exactly one clk cycle, then forced 0 on the next edge.
  - Never high on two consecutive cycles.
  - Registered on the rising edge, so it is stable across the following falling edge; a negedge-sampling flip-flop therefore sees exactly one active sample.
- Latency: t_out rises at rising edge SYNC_STAGES+DEBOUNCE_CYCLES+1, counting edge 1 as the first edge that samples btn_in=1, provided btn_in stays stable throughout.
- busy = 1 exactly in WAIT_HI or WAIT_LO (registered state decode).
- tog_en is sampled only on the commit cycle into IDLE_HI. If tog_en=0 then, that press produces no pulse, even if tog_en rises later in the same press.
- btn_in held high through reset release is treated as a fresh press: it is qualified and pulses.
- cnt saturates logically at DEBOUNCE_CYCLES-1 and never wraps.

Optional Feature:
- Macro: T_PULSE_AUTO_REPEAT_EN.
- Defined:
  - In IDLE_HI, a repeat counter rep_cnt counts clk cycles and clears on entry to IDLE_HI.
  - When rep_cnt==REPEAT_CYCLES-1: t_out←tog_en and rep_cnt←0.
  - Holding the button therefore yields a pulse every REPEAT_CYCLES cycles after the initial pulse.
  - Entering WAIT_LO clears rep_cnt.
- Undefined: no rep_cnt logic exists; exactly one pulse per press.

Decomposition:
- Package t_pulse_pkg holds:
  - the state enum (IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO, 2 bits);
  - default constants for DEBOUNCE_CYCLES and REPEAT_CYCLES.
- One sub-module: bit_sync, a parameterised SYNC_STAGES flop chain with synchronous active-low reset.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8):
- Clean press: btn_in 0→1 held, tog_en=1 → busy high edges 3–6; t_out high only after edge 7; btn_level=1 from edge 7.
- Bounce rejection: btn_in high 3 cycles, low 1, high 3, low → no t_out pulse, btn_level stays 0, busy returns to 0.
- Release: after a press, btn_in→0 for 10 cycles → btn_level falls after edge 7 of the release; t_out stays 0.
- tog_en=0 at commit, then 1 during the hold → btn_level=1, no t_out pulse for that press.
- Reset mid-WAIT_HI: rstn=0 for 1 cycle at cnt=2 → state IDLE_LO, outputs 0; with btn_in still high, a pulse follows 7 edges after reset release.
- With T_PULSE_AUTO_REPEAT_EN: hold 30 cycles → initial pulse, then pulses every 8 cycles (3 repeats); without the macro → exactly 1 pulse.

Source files
------------

// File: rtl/t_pulse_debounce_pkg.sv
// t_pulse_pkg: shared types and default constants for the button debouncer.
//   state_t              : debouncer FSM state encoding (2 bits)
//   SYNC_STAGES_DEF      : default synchroniser depth
//   DEBOUNCE_CYCLES_DEF  : default stable-input qualification time (clk cycles)
//   CNT_W_DEF            : default debounce counter width
//   REPEAT_CYCLES_DEF    : default auto-repeat period (clk cycles)
package t_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int CNT_W_DEF           = 16;
  localparam int REPEAT_CYCLES_DEF   = 500000;

endpackage

// File: rtl/t_pulse_debounce_if.sv
// t_pulse_debounce_if: button-side and status signals of the debouncer.
//   btn_in    : raw asynchronous button level (1 = pressed)
//   tog_en    : toggle enable, sampled when a press is committed
//   t_out     : one-cycle toggle pulse for the downstream T flip-flop
//   btn_level : debounced button level
//   busy      : a candidate level change is being qualified
// master: the stimulus / button side.  slave: the debouncer itself.
interface t_pulse_debounce_if;
  import t_pulse_pkg::*;

  logic btn_in;
  logic tog_en;
  logic t_out;
  logic btn_level;
  logic busy;

  modport master (
    output btn_in,
    output tog_en,
    input  t_out,
    input  btn_level,
    input  busy
  );

  modport slave (
    input  btn_in,
    input  tog_en,
    output t_out,
    output btn_level,
    output busy
  );

endinterface

// File: rtl/t_pulse_debounce_bit_sync.sv
// bit_sync: STAGES-deep flop chain bringing an asynchronous level into the
// clk domain. All flops clear on a synchronous active-low reset.
//   clk  : system clock
//   rstn : synchronous active-low reset
//   d    : asynchronous input level
//   q    : synchronised level (output of the last flop)
module bit_sync
  import t_pulse_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/t_pulse_debounce.sv
// t_pulse_debounce: synchronises and debounces a bouncing push-button and
// emits one single-cycle toggle pulse per debounced press.
//   clk  : system clock, all state updates on the rising edge
//   rstn : synchronous active-low reset
//   bus  : t_pulse_debounce_if.slave (btn_in, tog_en in; t_out, btn_level,
//          busy out)
// Optional feature: define T_PULSE_AUTO_REPEAT_EN to emit an extra pulse every
// REPEAT_CYCLES cycles while the button stays held. Without it, exactly one
// pulse is produced per press.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE_LO | debounced level is 0, waiting for the synced input to rise
// WAIT_HI | input high, counting stable cycles before accepting a press
// IDLE_HI | debounced level is 1 (auto-repeat counts here if enabled)
// WAIT_LO | input low, counting stable cycles before accepting release
module t_pulse_debounce
  import t_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input logic                 clk,
  input logic                 rstn,
  t_pulse_debounce_if.slave   bus
);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("t_pulse_debounce: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("t_pulse_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if ((DEBOUNCE_CYCLES >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("t_pulse_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  // A period of 1 would let a repeat pulse follow the commit pulse directly.
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("t_pulse_debounce: REPEAT_CYCLES must be >= 2");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef T_PULSE_AUTO_REPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt;
`endif

  logic             s_in;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             t_out_q;
  logic             level_q;
  logic             busy_q;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (bus.btn_in),
    .q    (s_in)
  );

  // busy is registered alongside the state it decodes, so it is written
  // wherever the next state is chosen rather than derived combinationally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE_LO;
      cnt     <= '0;
      t_out_q <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef T_PULSE_AUTO_REPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      // The pulse lasts one cycle unless a branch below re-asserts it.
      t_out_q <= 1'b0;

      case (state)
        IDLE_LO: begin
          if (s_in) begin
            state  <= WAIT_HI;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end

        WAIT_HI: begin
          if (!s_in) begin
            state  <= IDLE_LO;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE_HI;
            cnt     <= '0;
            busy_q  <= 1'b0;
            level_q <= 1'b1;
            t_out_q <= bus.tog_en;
`ifdef T_PULSE_AUTO_REPEAT_EN
            rep_cnt <= '0;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        IDLE_HI: begin
          if (!s_in) begin
            state  <= WAIT_LO;
            cnt    <= '0;
            busy_q <= 1'b1;
`ifdef T_PULSE_AUTO_REPEAT_EN
            rep_cnt <= '0;
`endif
          end else begin
`ifdef T_PULSE_AUTO_REPEAT_EN
            if (rep_cnt == REP_LAST) begin
              rep_cnt <= '0;
              t_out_q <= bus.tog_en;
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
`endif
          end
        end

        WAIT_LO: begin
          if (s_in) begin
            // Release was a bounce: back to held, no new pulse.
            state  <= IDLE_HI;
            cnt    <= '0;
            busy_q <= 1'b0;
`ifdef T_PULSE_AUTO_REPEAT_EN
            rep_cnt <= '0;
`endif
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE_LO;
            cnt     <= '0;
            busy_q  <= 1'b0;
            level_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE_LO;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.t_out     = t_out_q;
  assign bus.btn_level = level_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_t_pulse_debounce.sv
module tb_t_pulse_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int REP  = 8;

  logic clk;
  logic rstn;

  t_pulse_debounce_if dut_if ();

  t_pulse_debounce #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (4),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The debounced level flips once the synchronised input has disagreed with
  // it for DEB+1 consecutive edges (the first edge detects, DEB more qualify).
  logic       hist [SYNC];
  logic       m_level;
  logic       m_t;
  logic       m_busy;
  int         m_run;
  int         m_held;
  logic       started = 1'b0;

  always @(posedge clk) begin
    logic s;
    started = 1'b1;
    if (!rstn) begin
      for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
      m_level = 1'b0;
      m_t     = 1'b0;
      m_run   = 0;
      m_held  = 0;
    end else begin
      s = hist[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = dut_if.btn_in;
      m_t = 1'b0;
      if (s != m_level) begin
        m_held = 0;
        m_run++;
        if (m_run == DEB + 1) begin
          m_level = s;
          m_run   = 0;
          if (s) m_t = dut_if.tog_en;
        end
      end else begin
`ifdef T_PULSE_AUTO_REPEAT_EN
        // Count only edges spent continuously held (not the bounce-back edge).
        if (m_level && m_run == 0) begin
          m_held++;
          if (m_held == REP) begin
            m_held = 0;
            m_t    = dut_if.tog_en;
          end
        end
`endif
        m_run = 0;
      end
    end
    m_busy = (m_run != 0);
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  logic prev_t = 1'b0;
  always @(negedge clk) begin
    if (started) begin
      chk("model_t_out",     int'(dut_if.t_out),     int'(m_t));
      chk("model_btn_level", int'(dut_if.btn_level), int'(m_level));
      chk("model_busy",      int'(dut_if.busy),      int'(m_busy));
      if (prev_t) chk("t_out_back_to_back", int'(dut_if.t_out), 0);
      prev_t = dut_if.t_out;
    end
  end

  // Advance n cycles, returning the number of t_out pulses seen.
  task automatic hold(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dut_if.t_out) pulses++;
    end
  endtask

  int p;
  int seen_busy;
  logic [6:0] pat;

  initial begin
    rstn          = 1'b0;
    dut_if.btn_in = 1'b0;
    dut_if.tog_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_t_out",     int'(dut_if.t_out),     0);
    chk("reset_btn_level", int'(dut_if.btn_level), 0);
    chk("reset_busy",      int'(dut_if.busy),      0);
    rstn = 1'b1;
    hold(4, p);

    // Clean press: busy after edges 3..6, pulse after edge 7, level from 7.
    dut_if.btn_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("press_busy",  int'(dut_if.busy),      (k >= 3 && k <= 6) ? 1 : 0);
      chk("press_t_out", int'(dut_if.t_out),     (k == 7) ? 1 : 0);
      chk("press_level", int'(dut_if.btn_level), (k >= 7) ? 1 : 0);
    end

    // Release: level falls after edge 7, never a pulse.
    dut_if.btn_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("release_t_out", int'(dut_if.t_out),     0);
      chk("release_level", int'(dut_if.btn_level), (k < 7) ? 1 : 0);
      chk("release_busy",  int'(dut_if.busy),      (k >= 3 && k <= 6) ? 1 : 0);
    end

    // Bounce: high 3, low 1, high 3, then low.
    pat       = 7'b1110111;
    seen_busy = 0;
    p         = 0;
    for (int i = 0; i < 7; i++) begin
      dut_if.btn_in = pat[6-i];
      @(negedge clk);
      if (dut_if.t_out) p++;
      if (dut_if.busy) seen_busy = 1;
    end
    dut_if.btn_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dut_if.t_out) p++;
      if (dut_if.busy) seen_busy = 1;
      if (dut_if.btn_level) seen_busy = 2;
    end
    chk("bounce_pulses",     p,                      0);
    chk("bounce_busy_seen",  seen_busy,              1);
    chk("bounce_level_end",  int'(dut_if.btn_level), 0);
    chk("bounce_busy_end",   int'(dut_if.busy),      0);

    // tog_en low at commit, raised during the hold: no pulse for this press.
    dut_if.tog_en = 1'b0;
    dut_if.btn_in = 1'b1;
    hold(8, p);
    dut_if.tog_en = 1'b1;
    begin
      int p2;
      hold(5, p2);
      chk("togen_pulses", p + p2, 0);
    end
    chk("togen_level", int'(dut_if.btn_level), 1);
    dut_if.btn_in = 1'b0;
    hold(10, p);
    chk("togen_release_level", int'(dut_if.btn_level), 0);

    // Reset during WAIT_HI at cnt=2 (after edge 5), button kept high.
    dut_if.btn_in = 1'b1;
    hold(5, p);
    chk("midrst_busy_before", int'(dut_if.busy), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_busy",  int'(dut_if.busy),      0);
    chk("midrst_level", int'(dut_if.btn_level), 0);
    chk("midrst_t_out", int'(dut_if.t_out),     0);
    rstn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("postrst_t_out", int'(dut_if.t_out), (k == 7) ? 1 : 0);
    end
    dut_if.btn_in = 1'b0;
    hold(10, p);

    // Long hold of 30 cycles: pulses at edges 7 (and 15, 23, 31 with repeat).
    dut_if.btn_in = 1'b1;
    hold(30, p);
    dut_if.btn_in = 1'b0;
    begin
      int p2;
      hold(12, p2);
`ifdef T_PULSE_AUTO_REPEAT_EN
      chk("long_hold_pulses", p + p2, 4);
`else
      chk("long_hold_pulses", p + p2, 1);
`endif
    end
    chk("long_hold_level_end", int'(dut_if.btn_level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
